// File: rtl/mem_bytelane_ws.sv
// Purpose : byte-addressed little-endian data RAM with byte/half/word access,
//           load sign/zero extension, misalignment flag and req/ready handshake.
// Latency : accept edge k, commit and ready rise at edge k+LATENCY; one access per LATENCY+2 cycles.
// Backpressure: busy is high outside IDLE; req is only sampled in IDLE.
// Ports   : clk, rst (async, active-high)
//           req/we/size/sign_ext/addr/wdata - request captured in IDLE
//           ready/rdata/misalign          - one-cycle completion, registered result
//           busy                          - combinational, state != IDLE
module mem_bytelane_ws #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [DEPTH_LOG2+1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic [31:0]           rdata,
  output logic                  misalign,
  output logic                  busy
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [1:0]              r_size;
  logic                    r_sext;
  logic [DEPTH_LOG2+1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic                    r_ready;
  logic                    r_misalign;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [DEPTH];

  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = lane[0];
      2'b10:   f_misaligned = (lane != 2'b00);
      default: f_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic se);
    logic [31:0] sh;
    logic [15:0] hw;
    sh = word >> {lane, 3'b000};
    hw = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   f_extend = {{24{se & sh[7]}}, sh[7:0]};
      2'b01:   f_extend = {{16{se & hw[15]}}, hw};
      default: f_extend = word;
    endcase
  endfunction

  logic                  w_accept;
  logic                  w_mis_in;
  logic                  w_commit;
  logic                  w_c_we;
  logic [1:0]            w_c_size;
  logic                  w_c_sext;
  logic [DEPTH_LOG2+1:0] w_c_addr;
  logic [31:0]           w_c_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_wd_rep;
  logic [31:0]           w_ext;

  assign w_accept = (r_state == S_IDLE) && req;
  assign w_mis_in = f_misaligned(size, addr[1:0]);

  // With zero wait states the access commits on the accept edge itself, so the
  // commit path must see the live request rather than the captured copy.
  assign w_c_we    = (LATENCY == 0) ? we       : r_we;
  assign w_c_size  = (LATENCY == 0) ? size     : r_size;
  assign w_c_sext  = (LATENCY == 0) ? sign_ext : r_sext;
  assign w_c_addr  = (LATENCY == 0) ? addr     : r_addr;
  assign w_c_wdata = (LATENCY == 0) ? wdata    : r_wdata;

  assign w_commit = (LATENCY == 0) ? (w_accept && !w_mis_in)
                                   : ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_idx = w_c_addr[DEPTH_LOG2+1:2];

  always_comb begin
    w_be     = 4'b0000;
    w_wd_rep = w_c_wdata;
    case (w_c_size)
      2'b00: begin
        w_be     = 4'b0001 << w_c_addr[1:0];
        w_wd_rep = {4{w_c_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_c_addr[1] ? 4'b1100 : 4'b0011;
        w_wd_rep = {2{w_c_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_ext = f_extend(r_mem[w_idx], w_c_size, w_c_addr[1:0], w_c_sext);

  // RAM is not reset; a store still in flight when rst rises never commits.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_ready    <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (req) begin
            r_we       <= we;
            r_size     <= size;
            r_sext     <= sign_ext;
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_misalign <= w_mis_in;
            if (w_mis_in) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
            end else if (LATENCY > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_M1;
            end else begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              if (!we) r_rdata <= w_ext;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            if (!r_we) r_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign rdata    = r_rdata;
  assign misalign = r_misalign;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bytelane_ws.sv
module tb_mem_bytelane_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [10:0] addr = '0;
  logic [31:0] wdata = 32'h0;

  logic        ready0, misalign0, busy0;
  logic [31:0] rdata0;
  logic        ready1, misalign1, busy1;
  logic [31:0] rdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bytelane_ws #(.DEPTH_LOG2(9), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready0), .rdata(rdata0),
    .misalign(misalign0), .busy(busy0)
  );

  mem_bytelane_ws #(.DEPTH_LOG2(9), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready1), .rdata(rdata1),
    .misalign(misalign1), .busy(busy1)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ready(input bit u);
    return u ? ready1 : ready0;
  endfunction

  function automatic logic cur_busy(input bit u);
    return u ? busy1 : busy0;
  endfunction

  // One access: present at a negedge, accepted on the next posedge, then
  // wait (bounded) until ready is seen at a negedge.
  task automatic access(input bit u, input logic w, input logic [1:0] sz, input logic se,
                        input logic [10:0] a, input logic [31:0] wd,
                        output int cyc, output int bcnt);
    bit got;
    @(negedge clk);
    we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    if (u) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    cyc = 0; bcnt = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cur_busy(u)) bcnt++;
      if (cur_ready(u)) got = 1'b1;
    end
    if (!got) expect_eq("ready_timeout", 32'(got), 32'd1);
  endtask

  task automatic ld(input bit u, input logic [1:0] sz, input logic se, input logic [10:0] a,
                    input logic [31:0] exp_rd, input logic exp_mis, input string tag);
    int c, b;
    access(u, 1'b0, sz, se, a, 32'h0, c, b);
    expect_eq({tag, "_rdata"}, u ? rdata1 : rdata0, exp_rd);
    expect_eq({tag, "_mis"}, 32'(u ? misalign1 : misalign0), 32'(exp_mis));
  endtask

  task automatic st(input bit u, input logic [1:0] sz, input logic [10:0] a,
                    input logic [31:0] wd, input logic exp_mis, input string tag);
    int c, b;
    access(u, 1'b1, sz, 1'b0, a, wd, c, b);
    expect_eq({tag, "_mis"}, 32'(u ? misalign1 : misalign0), 32'(exp_mis));
  endtask

  initial begin
    int c, b, cnt;

    // Outputs while held in reset
    repeat (2) @(negedge clk);
    expect_eq("rst_ready", 32'(ready0), 32'd0);
    expect_eq("rst_busy", 32'(busy0), 32'd0);
    expect_eq("rst_mis", 32'(misalign0), 32'd0);
    expect_eq("rst_rdata", rdata0, 32'h0);
    rst = 1'b0;

    // Word store, LATENCY=2: ready seen 3 cycles after accept, busy for 3
    access(1'b0, 1'b1, 2'b10, 1'b0, 11'h004, 32'hDEADBEEF, c, b);
    expect_eq("st_w_cycles", 32'(c), 32'd3);
    expect_eq("st_w_busy", 32'(b), 32'd3);
    expect_eq("st_w_mis", 32'(misalign0), 32'd0);
    @(negedge clk);
    expect_eq("st_w_idle_busy", 32'(busy0), 32'd0);
    expect_eq("st_w_idle_ready", 32'(ready0), 32'd0);

    st(1'b0, 2'b00, 11'h005, 32'h000000AA, 1'b0, "st_b5");
    ld(1'b0, 2'b10, 1'b0, 11'h004, 32'hDEADAAEF, 1'b0, "ld_w4");
    ld(1'b0, 2'b00, 1'b1, 11'h005, 32'hFFFFFFAA, 1'b0, "ld_b5_s");
    ld(1'b0, 2'b00, 1'b0, 11'h005, 32'h000000AA, 1'b0, "ld_b5_z");
    ld(1'b0, 2'b01, 1'b1, 11'h006, 32'hFFFFDEAD, 1'b0, "ld_h6_s");
    ld(1'b0, 2'b01, 1'b1, 11'h007, 32'hFFFFDEAD, 1'b1, "ld_h7_mis");
    st(1'b0, 2'b11, 11'h004, 32'h00000000, 1'b1, "st_sz11");
    expect_eq("st_sz11_rdata", rdata0, 32'hFFFFDEAD);
    st(1'b0, 2'b10, 11'h006, 32'h00000000, 1'b1, "st_w6_mis");
    ld(1'b0, 2'b10, 1'b0, 11'h004, 32'hDEADAAEF, 1'b0, "ld_w4_again");
    ld(1'b0, 2'b01, 1'b0, 11'h004, 32'h0000AAEF, 1'b0, "ld_h4_z");
    ld(1'b0, 2'b01, 1'b1, 11'h004, 32'hFFFFAAEF, 1'b0, "ld_h4_s");
    ld(1'b0, 2'b00, 1'b1, 11'h007, 32'hFFFFFFDE, 1'b0, "ld_b7_s");
    ld(1'b0, 2'b00, 1'b1, 11'h004, 32'hFFFFFFEF, 1'b0, "ld_b4_s");
    st(1'b0, 2'b01, 11'h006, 32'h00001234, 1'b0, "st_h6");
    ld(1'b0, 2'b10, 1'b1, 11'h004, 32'h1234AAEF, 1'b0, "ld_w4_h");
    ld(1'b0, 2'b00, 1'b0, 11'h006, 32'h00000034, 1'b0, "ld_b6_z");
    ld(1'b0, 2'b11, 1'b0, 11'h000, 32'h00000034, 1'b1, "ld_sz11");

    // req toggled while in WAIT must not start another access
    @(negedge clk);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 11'h004; req0 = 1'b1;
    @(posedge clk);
    #1 req0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready0) begin
        cnt++;
        expect_eq("tog_rdata", rdata0, 32'h1234AAEF);
      end
      req0 = (i == 0);
    end
    expect_eq("tog_ready_count", 32'(cnt), 32'd1);

    // Reset during WAIT of a store discards it
    st(1'b0, 2'b10, 11'h010, 32'h12345678, 1'b0, "st_w10");
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 11'h010; wdata = 32'hCAFEF00D; req0 = 1'b1;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    expect_eq("pre_rst_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    #1;
    expect_eq("midrst_ready", 32'(ready0), 32'd0);
    expect_eq("midrst_busy", 32'(busy0), 32'd0);
    expect_eq("midrst_mis", 32'(misalign0), 32'd0);
    expect_eq("midrst_rdata", rdata0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready0) cnt++;
      if (i == 2) rst = 1'b0;
    end
    expect_eq("midrst_no_ready", 32'(cnt), 32'd0);
    ld(1'b0, 2'b10, 1'b0, 11'h010, 32'h12345678, 1'b0, "ld_w10_after_rst");

    // LATENCY=0 instance: req held high gives ready every second cycle
    @(negedge clk);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 11'h000; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expect_eq($sformatf("lat0_ready_%0d", i), 32'(ready1), 32'((i % 2) == 0));
    end
    req1 = 1'b0;
    @(negedge clk);
    access(1'b1, 1'b1, 2'b10, 1'b0, 11'h7FC, 32'hA5A55A5A, c, b);
    expect_eq("lat0_st_cycles", 32'(c), 32'd1);
    ld(1'b1, 2'b10, 1'b0, 11'h7FC, 32'hA5A55A5A, 1'b0, "lat0_ld_7fc");
    ld(1'b1, 2'b01, 1'b1, 11'h7FE, 32'hFFFFA5A5, 1'b0, "lat0_ld_h7fe");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
